// File: rtl/digdug_spatr_arbiter_if.sv
// ============================================================================
// Module   : digdug_spatr_arbiter_if
// Brief    : Renderer, CPU and attribute-RAM signal bundle for the arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface digdug_spatr_arbiter_if;
    logic        SP_RD;
    logic [6:0]  SP_AD;
    logic        SP_GNT;
    logic        SP_VLD;
    logic [23:0] SP_DT;
    logic        CPU_REQ;
    logic        CPU_WE;
    logic [8:0]  CPU_AD;
    logic [7:0]  CPU_DI;
    logic [7:0]  CPU_DO;
    logic        CPU_ACK;
    logic [6:0]  RAM_AD;
    logic [2:0]  RAM_WE;
    logic [23:0] RAM_WD;
    logic [23:0] RAM_RD;

    modport slave (
        input  SP_RD, SP_AD, CPU_REQ, CPU_WE, CPU_AD, CPU_DI, RAM_RD,
        output SP_GNT, SP_VLD, SP_DT, CPU_DO, CPU_ACK, RAM_AD, RAM_WE, RAM_WD
    );

    modport master (
        output SP_RD, SP_AD, CPU_REQ, CPU_WE, CPU_AD, CPU_DI, RAM_RD,
        input  SP_GNT, SP_VLD, SP_DT, CPU_DO, CPU_ACK, RAM_AD, RAM_WE, RAM_WD
    );
endinterface

`default_nettype wire

// File: rtl/digdug_spatr_arbiter.sv
// ============================================================================
// Module   : digdug_spatr_arbiter
// Brief    : Sprite-attribute RAM arbiter, sprite reads first, CPU byte lanes.
//            Optional CPU starvation guard: DIGDUG_SPATR_CPU_GUARD_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module digdug_spatr_arbiter #(
    parameter int CPU_WAIT_LIMIT = 8
) (
    input  wire logic              RCLK,
    input  wire logic              RST_N,
    digdug_spatr_arbiter_if.slave  bus
);

    if ((CPU_WAIT_LIMIT < 1) || (CPU_WAIT_LIMIT > 255)) begin : g_bad_limit
        $error("CPU_WAIT_LIMIT must be within 1..255");
    end

    logic        r_sp_vld;
    logic [23:0] r_sp_dt;
    logic        r_cpu_inflt;
    logic        r_cpu_ack;
    logic        r_cpu_we;
    logic [1:0]  r_cpu_lane;
    logic [7:0]  r_cpu_do;

    logic        w_cpu_elig;
    logic        w_force;
    logic        w_sp_gnt;
    logic        w_cpu_gnt;
    logic [1:0]  w_cpu_lane;
    logic [7:0]  w_rd_byte;
    logic [6:0]  w_ram_ad;
    logic [2:0]  w_ram_we;

    assign w_cpu_lane = bus.CPU_AD[8:7];
    // The ACK cycle is excluded so a request still held during ACK is not re-granted.
    assign w_cpu_elig = bus.CPU_REQ & ~r_cpu_inflt & ~r_cpu_ack;

`ifdef DIGDUG_SPATR_CPU_GUARD_EN
    localparam logic [7:0] c_WAIT_LIMIT = 8'(CPU_WAIT_LIMIT);

    logic [7:0] r_wait_cnt;

    always_ff @(posedge RCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wait_cnt <= 8'd0;
        end else if (!bus.CPU_REQ || w_cpu_gnt) begin
            r_wait_cnt <= 8'd0;
        end else if (w_cpu_elig && (r_wait_cnt != 8'hFF)) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    assign w_force = w_cpu_elig & (r_wait_cnt == c_WAIT_LIMIT);
`else
    assign w_force = 1'b0;
`endif

    assign w_sp_gnt  = RST_N & bus.SP_RD & ~w_force;
    assign w_cpu_gnt = RST_N & ~w_sp_gnt & w_cpu_elig;

    always_comb begin
        w_ram_ad = 7'd0;
        w_ram_we = 3'b000;
        if (w_sp_gnt) begin
            w_ram_ad = bus.SP_AD;
        end else if (w_cpu_gnt) begin
            w_ram_ad = bus.CPU_AD[6:0];
            if (bus.CPU_WE) begin
                case (w_cpu_lane)
                    2'd0:    w_ram_we = 3'b001;
                    2'd1:    w_ram_we = 3'b010;
                    2'd2:    w_ram_we = 3'b100;
                    default: w_ram_we = 3'b000;
                endcase
            end
        end
    end

    always_comb begin
        w_rd_byte = 8'hFF;
        case (r_cpu_lane)
            2'd0:    w_rd_byte = bus.RAM_RD[7:0];
            2'd1:    w_rd_byte = bus.RAM_RD[15:8];
            2'd2:    w_rd_byte = bus.RAM_RD[23:16];
            default: w_rd_byte = 8'hFF;
        endcase
    end

    always_ff @(posedge RCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sp_vld    <= 1'b0;
            r_sp_dt     <= 24'd0;
            r_cpu_inflt <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_cpu_we    <= 1'b0;
            r_cpu_lane  <= 2'd0;
            r_cpu_do    <= 8'd0;
        end else begin
            r_sp_vld    <= w_sp_gnt;
            r_cpu_inflt <= w_cpu_gnt;
            r_cpu_ack   <= w_cpu_gnt;
            if (w_cpu_gnt) begin
                r_cpu_we   <= bus.CPU_WE;
                r_cpu_lane <= w_cpu_lane;
            end
            if (r_sp_vld) begin
                r_sp_dt <= bus.RAM_RD;
            end
            if (r_cpu_ack && !r_cpu_we) begin
                r_cpu_do <= w_rd_byte;
            end
        end
    end

    // The RAM output register times the data; the hold registers keep the last value.
    assign bus.SP_GNT  = w_sp_gnt;
    assign bus.SP_VLD  = r_sp_vld;
    assign bus.SP_DT   = r_sp_vld ? bus.RAM_RD : r_sp_dt;
    assign bus.CPU_ACK = r_cpu_ack;
    assign bus.CPU_DO  = (r_cpu_ack && !r_cpu_we) ? w_rd_byte : r_cpu_do;
    assign bus.RAM_AD  = w_ram_ad;
    assign bus.RAM_WE  = w_ram_we;
    assign bus.RAM_WD  = RST_N ? {3{bus.CPU_DI}} : 24'd0;

endmodule

`default_nettype wire

// File: tb/tb_digdug_spatr_arbiter.sv
// ============================================================================
// Module   : tb_digdug_spatr_arbiter
// Brief    : Scoreboard bench for the sprite-attribute RAM arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_digdug_spatr_arbiter;

    logic RCLK  = 1'b0;
    logic RST_N = 1'b1;
    logic mon_en = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [23:0] exp_sp  [$];
    logic [7:0]  exp_cpu [$];
    logic [23:0] mem [128];

    always #5 RCLK = ~RCLK;

    digdug_spatr_arbiter_if bus ();

    digdug_spatr_arbiter #(.CPU_WAIT_LIMIT(8)) dut (
        .RCLK  (RCLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    // Synchronous attribute RAM; preloaded with 24'h000100*n while reset is held.
    always @(posedge RCLK) begin
        if (!RST_N) begin
            for (int i = 0; i < 128; i++) mem[i] <= 24'(i * 256);
        end else begin
            for (int l = 0; l < 3; l++)
                if (bus.RAM_WE[l]) mem[bus.RAM_AD][l*8 +: 8] <= bus.RAM_WD[l*8 +: 8];
        end
        bus.RAM_RD <= mem[bus.RAM_AD];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge RCLK) begin
        if (mon_en && RST_N) begin
            if (bus.SP_VLD === 1'b1) begin
                if (exp_sp.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL sp_vld_unexpected: got data %0h expected no valid", bus.SP_DT);
                end else begin
                    chk("sp_dt", 32'(bus.SP_DT), 32'(exp_sp.pop_front()));
                end
            end
            if (bus.CPU_ACK === 1'b1) begin
                if (exp_cpu.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL cpu_ack_unexpected: got ack do=%0h expected no ack", bus.CPU_DO);
                end else begin
                    chk("cpu_do", 32'(bus.CPU_DO), 32'(exp_cpu.pop_front()));
                end
            end
        end
    end

    task automatic tick;
        @(posedge RCLK);
        #1;
    endtask

    task automatic at_neg;
        @(negedge RCLK);
    endtask

    task automatic cpu_access(input logic we, input logic [8:0] ad, input logic [7:0] di,
                              input logic [2:0] exp_we, input logic [7:0] exp_do);
        logic [6:0] wa;
        wa = ad[6:0];
        tick;
        bus.CPU_REQ = 1'b1; bus.CPU_WE = we; bus.CPU_AD = ad; bus.CPU_DI = di;
        exp_cpu.push_back(exp_do);
        at_neg;
        chk("cpu_ram_we", 32'(bus.RAM_WE), 32'(exp_we));
        chk("cpu_ram_ad", 32'(bus.RAM_AD), 32'(wa));
        if (we) chk("cpu_ram_wd", 32'(bus.RAM_WD), 32'({3{di}}));
        at_neg;
        chk("cpu_ack_lat", 32'(bus.CPU_ACK), 32'd1);
        bus.CPU_REQ = 1'b0;
        at_neg;
        chk("cpu_single_ack", 32'(bus.CPU_ACK), 32'd0);
    endtask

    initial begin
        bus.SP_RD = 1'b1; bus.SP_AD = 7'h55;
        bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b1; bus.CPU_AD = 9'h105; bus.CPU_DI = 8'h3C;

        // Reset asserted mid-cycle with requests pending
        repeat (2) @(posedge RCLK);
        #3 RST_N = 1'b0;
        #1;
        chk("rst_sp_gnt",  32'(bus.SP_GNT),  32'd0);
        chk("rst_ram_ad",  32'(bus.RAM_AD),  32'd0);
        chk("rst_ram_we",  32'(bus.RAM_WE),  32'd0);
        chk("rst_ram_wd",  32'(bus.RAM_WD),  32'd0);
        chk("rst_sp_vld",  32'(bus.SP_VLD),  32'd0);
        chk("rst_sp_dt",   32'(bus.SP_DT),   32'd0);
        chk("rst_cpu_do",  32'(bus.CPU_DO),  32'd0);
        chk("rst_cpu_ack", 32'(bus.CPU_ACK), 32'd0);
        bus.SP_RD = 1'b0; bus.SP_AD = 7'd0;
        bus.CPU_REQ = 1'b0; bus.CPU_WE = 1'b0; bus.CPU_AD = 9'd0; bus.CPU_DI = 8'd0;
        repeat (2) @(posedge RCLK);
        at_neg;
        RST_N  = 1'b1;
        mon_en = 1'b1;
        tick;
        at_neg;
        chk("idle_ram_we", 32'(bus.RAM_WE), 32'd0);
        chk("idle_ram_ad", 32'(bus.RAM_AD), 32'd0);
        chk("idle_sp_gnt", 32'(bus.SP_GNT), 32'd0);

        // CPU lane accesses: mem[5]=000500 becomes A50500
        cpu_access(1'b1, 9'h105, 8'hA5, 3'b100, 8'h00);
        cpu_access(1'b0, 9'h105, 8'h00, 3'b000, 8'hA5);
        cpu_access(1'b0, 9'h085, 8'h00, 3'b000, 8'h05);
        cpu_access(1'b1, 9'h183, 8'h5A, 3'b000, 8'h05);
        cpu_access(1'b0, 9'h183, 8'h00, 3'b000, 8'hFF);

        // Sprite burst of four words
        for (int i = 0; i < 4; i++) begin
            tick;
            bus.SP_RD = 1'b1; bus.SP_AD = 7'(i);
            exp_sp.push_back(24'(i * 256));
            at_neg;
            chk("burst_sp_gnt", 32'(bus.SP_GNT), 32'd1);
            chk("burst_ram_ad", 32'(bus.RAM_AD), 32'(i));
            chk("burst_ram_we", 32'(bus.RAM_WE), 32'd0);
        end
        tick;
        bus.SP_RD = 1'b0;
        at_neg;
        chk("burst_end_gnt", 32'(bus.SP_GNT), 32'd0);

`ifndef DIGDUG_SPATR_CPU_GUARD_EN
        // Absolute sprite priority starves the CPU until SP_RD drops
        tick;
        bus.SP_RD = 1'b1; bus.SP_AD = 7'd0;
        bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b0; bus.CPU_AD = 9'h082;
        exp_cpu.push_back(8'h02);
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin
                tick;
                bus.SP_AD = 7'(c % 4);
            end
            exp_sp.push_back(24'((c % 4) * 256));
            at_neg;
            chk("cont_sp_gnt", 32'(bus.SP_GNT), 32'd1);
            chk("cont_no_ack", 32'(bus.CPU_ACK), 32'd0);
        end
        tick;
        bus.SP_RD = 1'b0;
        at_neg;
        chk("cont_gnt_drop", 32'(bus.SP_GNT), 32'd0);
        chk("cont_cpu_ad", 32'(bus.RAM_AD), 32'd2);
        at_neg;
        chk("cont_ack", 32'(bus.CPU_ACK), 32'd1);
        bus.CPU_REQ = 1'b0;
`else
        // Guard forces the CPU in on the ninth contended cycle
        tick;
        bus.SP_RD = 1'b1; bus.SP_AD = 7'd1;
        bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b0; bus.CPU_AD = 9'h082;
        exp_cpu.push_back(8'h02);
        for (int c = 1; c <= 10; c++) begin
            if (c != 9) exp_sp.push_back(24'h000100);
            at_neg;
            chk("guard_sp_gnt", 32'(bus.SP_GNT), (c == 9) ? 32'd0 : 32'd1);
            chk("guard_ack", 32'(bus.CPU_ACK), (c == 10) ? 32'd1 : 32'd0);
            if (c == 9) chk("guard_cpu_ad", 32'(bus.RAM_AD), 32'd2);
            if (c == 10) bus.CPU_REQ = 1'b0;
            else tick;
        end
        tick;
        bus.SP_RD = 1'b0;
        at_neg;
`endif

        tick;
        tick;
        at_neg;
        chk("sp_queue_drained",  32'(exp_sp.size()),  32'd0);
        chk("cpu_queue_drained", 32'(exp_cpu.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/digdug_spatr_arbiter.md
Name: digdug_spatr_arbiter

Overview:
- Shares the 128-entry x 24-bit sprite attribute RAM between two requesters:
  - the sprite line renderer, which needs a 24-bit word per read;
  - the main CPU, which accesses the RAM as three 128-byte banks, one per byte lane.
- Sits between the CPU bus decode and the attribute RAM, and drives the renderer's attribute read port.
- Sprite reads have priority. An optional starvation guard bounds CPU wait time.

Parameters:
- CPU_WAIT_LIMIT, 8, number of consecutive denied CPU-pending cycles before the CPU is forced a slot. Used only with the optional feature; legal range 1..255.

Ports:
- RCLK  in  1  rendering clock; all state updates on its rising edge
- RST_N  in  1  asynchronous active-low reset
- SP_RD  in  1  renderer read request; held until granted
- SP_AD  in  7  renderer word address
- SP_GNT  out  1  renderer request accepted this cycle (combinational)
- SP_VLD  out  1  renderer read data valid (registered)
- SP_DT  out  24  renderer read data (registered)
- CPU_REQ  in  1  CPU access request, level; held until CPU_ACK
- CPU_WE  in  1  1 = write, 0 = read
- CPU_AD  in  9  [8:7] byte lane (0: [7:0], 1: [15:8], 2: [23:16], 3: invalid); [6:0] word address
- CPU_DI  in  8  CPU write data
- CPU_DO  out  8  CPU read data (registered)
- CPU_ACK  out  1  one-cycle transaction-complete pulse (registered)
- RAM_AD  out  7  RAM address (combinational from the grant mux)
- RAM_WE  out  3  per-lane write enables (combinational)
- RAM_WD  out  24  write data; CPU_DI replicated to all three lanes
- RAM_RD  in  24  RAM read data; synchronous RAM, valid 1 cycle after address

Behaviour:
- Reset (async, RST_N low): SP_VLD=0, SP_DT=0, CPU_DO=0, CPU_ACK=0, wait counter=0, CPU in-flight flag=0. Combinational outputs drive 0 while in reset.
- Arbitration is evaluated every cycle:
  - If SP_RD=1 and no CPU force this cycle: sprite granted. SP_GNT=1, RAM_AD=SP_AD, RAM_WE=0.
  - Else, if CPU_REQ=1, CPU not in flight, and CPU_ACK=0 this cycle: CPU granted. RAM_AD=CPU_AD[6:0].
    - Write, lane 0..2: RAM_WE is one-hot for that lane, RAM_WD={3{CPU_DI}}.
    - Write, lane 3: RAM_WE=0.
  - Otherwise: idle. RAM_AD=0, RAM_WE=0.
- Sprite latency:
  - SP_VLD=1 and SP_DT=RAM_RD in the cycle after grant.
  - Back-to-back grants give one word per cycle.
  - The renderer holds SP_RD/SP_AD stable while SP_GNT=0.
- CPU latency:
  - A grant sets the in-flight flag.
  - Next cycle: CPU_ACK=1 and the flag clears.
    - Read: CPU_DO = selected lane of RAM_RD, or 8'hFF for lane 3.
    - Write: CPU_DO holds its previous value.
  - CPU_REQ is ignored during the ACK cycle, so one request yields exactly one ACK.
  - The CPU may re-request on the cycle after ACK.
- Simultaneous SP_RD and CPU_REQ: the sprite wins unless the force condition applies.
- No transaction is cancelled mid-flight; an outstanding ACK or SP_VLD always completes.
- Reset asserted mid-transaction discards the transaction; no ACK or VLD is issued after reset.
- All RAM writes come from the CPU; the renderer never writes.

Optional Feature:
- Macro: DIGDUG_SPATR_CPU_GUARD_EN.
- Enabled:
  - An 8-bit wait counter increments on every cycle where CPU_REQ=1, no in-flight, no ACK, and the CPU is not granted.
  - The counter clears on CPU grant or when CPU_REQ=0. It saturates at 255.
  - When counter == CPU_WAIT_LIMIT, the CPU is forced: CPU granted, SP_GNT=0 for that cycle, and the renderer retries next cycle.
- Disabled:
  - No counter logic.
  - Sprite priority is absolute, so the CPU waits indefinitely while SP_RD stays high.

Test Plan:
- Reset then idle:
  - Drive RST_N low mid-cycle.
  - Expect all outputs 0 immediately; after release with no requests, RAM_WE=0 and RAM_AD=0.
- CPU write then read:
  - Write CPU_AD=9'h105 (lane 2, addr 5), DI=8'hA5. Expect RAM_WE=3'b100, RAM_WD=24'hA5A5A5, and ACK one cycle later.
  - Read the same address. Expect ACK with CPU_DO=8'hA5.
- Invalid lane:
  - Write CPU_AD=9'h183. Expect RAM_WE=0 and ACK.
  - Read the same address. Expect CPU_DO=8'hFF.
- Sprite burst:
  - SP_RD high for 4 cycles, SP_AD=0..3, RAM preloaded with 24'h000100*n.
  - Expect SP_GNT=1 for 4 cycles and SP_VLD with matching words, each one cycle after grant.
- Contention without the guard (macro off):
  - Hold SP_RD=1 for 20 cycles with CPU_REQ pending. Expect no CPU_ACK.
  - Drop SP_RD. Expect CPU grant in that cycle and ACK the next.
- Guard (macro on, CPU_WAIT_LIMIT=8):
  - SP_RD held high, CPU_REQ raised. Expect SP_GNT=0 for exactly one cycle on the 9th cycle, CPU_ACK on the 10th, and sprite grants resuming on the 10th.
